// File: rtl/alu_pipe_hs.sv
// Two-stage pipelined ALU with valid/ready handshakes on both sides.
// It provides Z/C/V flags and an accumulator for chained operations.
module alu_pipe_hs #(
    parameter int N      = 8,
    parameter bit ACC_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   op,
    input  logic [N-1:0] in0,
    input  logic [N-1:0] in1,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out,
    output logic         flag_z,
    output logic         flag_c,
    output logic         flag_v,
    output logic [N-1:0] acc
);

    typedef enum logic [2:0] {
        OP_ADD     = 3'b000,
        OP_OR      = 3'b001,
        OP_SUB     = 3'b010,
        OP_XOR     = 3'b011,
        OP_AND     = 3'b100,
        OP_ACC_ADD = 3'b101,
        OP_ACC_LD  = 3'b110,
        OP_PASS    = 3'b111
    } op_e;

    logic         s1_valid;
    op_e          s1_op;
    logic [N-1:0] s1_a;
    logic [N-1:0] s1_b;
    logic         s2_valid;

    logic         adv1;
    logic         adv2;

    op_e          eff_op;
    logic [N-1:0] add_a;
    logic [N:0]   sum;
    logic [N-1:0] diff;
    logic [N-1:0] res;
    logic         res_c;
    logic         res_v;
    logic         acc_we;

    assign adv2      = !s2_valid || out_ready;
    assign adv1      = s1_valid && adv2;
    assign in_ready  = !s1_valid || adv2;
    assign out_valid = s2_valid;

    // Without the accumulator, both acc opcodes behave as a plain ADD.
    always_comb begin
        eff_op = s1_op;
        if (!ACC_EN && (s1_op == OP_ACC_ADD || s1_op == OP_ACC_LD)) begin
            eff_op = OP_ADD;
        end
    end

    always_comb begin
        add_a  = (eff_op == OP_ACC_ADD) ? acc : s1_a;
        sum    = {1'b0, add_a} + {1'b0, s1_b};
        diff   = s1_a - s1_b;
        res    = '0;
        res_c  = 1'b0;
        res_v  = 1'b0;
        acc_we = 1'b0;
        case (eff_op)
            OP_ADD, OP_ACC_ADD: begin
                res    = sum[N-1:0];
                res_c  = sum[N];
                res_v  = (add_a[N-1] == s1_b[N-1]) && (sum[N-1] != add_a[N-1]);
                acc_we = (eff_op == OP_ACC_ADD);
            end
            OP_SUB: begin
                res   = diff;
                res_c = (s1_a < s1_b);
                res_v = (s1_a[N-1] != s1_b[N-1]) && (diff[N-1] != s1_a[N-1]);
            end
            OP_OR:     res = s1_a | s1_b;
            OP_XOR:    res = s1_a ^ s1_b;
            OP_AND:    res = s1_a & s1_b;
            OP_ACC_LD: begin
                res    = s1_b;
                acc_we = 1'b1;
            end
            OP_PASS:   res = s1_a;
            default:   res = '0;
        endcase
    end

    // Stage 1 refills whenever it is empty or is draining into stage 2 this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= OP_ADD;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_op <= op_e'(op);
                s1_a  <= in0;
                s1_b  <= in1;
            end
        end
    end

    // The accumulator commits only when its op moves into the output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            out      <= '0;
            flag_z   <= 1'b0;
            flag_c   <= 1'b0;
            flag_v   <= 1'b0;
            acc      <= '0;
        end else begin
            if (adv2) begin
                s2_valid <= s1_valid;
            end
            if (adv1) begin
                out    <= res;
                flag_z <= (res == '0);
                flag_c <= res_c;
                flag_v <= res_v;
                if (acc_we) begin
                    acc <= res;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe_hs.sv
// Directed testbench for alu_pipe_hs (N=8). Expected results are computed by hand,
// queued in acceptance order and compared by a monitor as each result is popped.
module tb_alu_pipe_hs;

    localparam logic [2:0] ADD     = 3'b000;
    localparam logic [2:0] OR_OP   = 3'b001;
    localparam logic [2:0] SUB     = 3'b010;
    localparam logic [2:0] XOR_OP  = 3'b011;
    localparam logic [2:0] AND_OP  = 3'b100;
    localparam logic [2:0] ACC_ADD = 3'b101;
    localparam logic [2:0] ACC_LD  = 3'b110;
    localparam logic [2:0] PASS    = 3'b111;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    logic [7:0] in0;
    logic [7:0] in1;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out;
    logic       flag_z;
    logic       flag_c;
    logic       flag_v;
    logic [7:0] acc;

    typedef struct {
        logic [7:0] res;
        logic       c;
        logic       v;
        logic       z;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   pops = 0;
    int   stall_cycles = 0;
    bit   mon_en = 1'b0;

    alu_pipe_hs #(.N(8), .ACC_EN(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .in0       (in0),
        .in1       (in1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .flag_z    (flag_z),
        .flag_c    (flag_c),
        .flag_v    (flag_v),
        .acc       (acc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Called just after a rising edge; returns just after the edge that accepted it.
    task automatic applyStimulus(input logic [2:0] o, input logic [7:0] a,
                                 input logic [7:0] b, input logic [7:0] r,
                                 input logic c, input logic v, input logic z);
        exp_t e;
        int   waited;
        op       = o;
        in0      = a;
        in1      = b;
        in_valid = 1'b1;
        e.res = r;
        e.c   = c;
        e.v   = v;
        e.z   = z;
        exp_q.push_back(e);
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            waited++;
            stall_cycles++;
            @(negedge clk);
        end
        if (!in_ready) checkOutput("accept_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic waitDrain();
        int guard;
        in_valid = 1'b0;
        guard = 0;
        while (exp_q.size() != 0 && guard < 60) begin
            guard++;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        checkOutput("drain_queue", exp_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en && rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("spurious_out_valid", {31'd0, out_valid}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                pops++;
                checkOutput("out", {24'd0, out}, {24'd0, mon_e.res});
                checkOutput("flag_c", {31'd0, flag_c}, {31'd0, mon_e.c});
                checkOutput("flag_v", {31'd0, flag_v}, {31'd0, mon_e.v});
                checkOutput("flag_z", {31'd0, flag_z}, {31'd0, mon_e.z});
            end
        end
    end

    logic [7:0] bp_a [4];
    logic [7:0] held;
    logic       took;
    int         idx;
    int         accepted;
    int         guard;
    int         pops_before;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op        = 3'b000;
        in0       = 8'h00;
        in1       = 8'h00;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_out", {24'd0, out}, 32'd0);
        checkOutput("rst_flags", {29'd0, flag_z, flag_c, flag_v}, 32'd0);
        checkOutput("rst_acc", {24'd0, acc}, 32'd0);
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Latency: accepted on edge k, out_valid visible after edge k+1.
        applyStimulus(ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("lat_edge_k", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        checkOutput("lat_edge_k1", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1;
        waitDrain();

        applyStimulus(ADD,    8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1);
        applyStimulus(SUB,    8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0);
        applyStimulus(SUB,    8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0);
        applyStimulus(SUB,    8'h05, 8'h05, 8'h00, 1'b0, 1'b0, 1'b1);
        applyStimulus(OR_OP,  8'hA0, 8'h0A, 8'hAA, 1'b0, 1'b0, 1'b0);
        applyStimulus(XOR_OP, 8'hFF, 8'h0F, 8'hF0, 1'b0, 1'b0, 1'b0);
        applyStimulus(AND_OP, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0);
        applyStimulus(PASS,   8'h5A, 8'h11, 8'h5A, 1'b0, 1'b0, 1'b0);
        waitDrain();

        // Back-to-back accumulator chain must never stall the input.
        stall_cycles = 0;
        applyStimulus(ACC_LD,  8'h99, 8'h05, 8'h05, 1'b0, 1'b0, 1'b0);
        applyStimulus(ACC_ADD, 8'h99, 8'h03, 8'h08, 1'b0, 1'b0, 1'b0);
        applyStimulus(ACC_ADD, 8'h99, 8'hFA, 8'h02, 1'b1, 1'b0, 1'b0);
        checkOutput("acc_chain_stalls", stall_cycles, 32'd0);
        waitDrain();
        checkOutput("acc_chain_acc", {24'd0, acc}, 32'h02);

        // Backpressure: four ADDs streamed while the consumer stalls for 5 cycles.
        bp_a[0] = 8'h01;
        bp_a[1] = 8'h02;
        bp_a[2] = 8'h03;
        bp_a[3] = 8'h04;
        for (int i = 0; i < 4; i++) begin
            mon_e.res = bp_a[i] + bp_a[i];
            mon_e.c   = 1'b0;
            mon_e.v   = 1'b0;
            mon_e.z   = 1'b0;
            exp_q.push_back(mon_e);
        end
        pops_before = pops;
        out_ready = 1'b0;
        idx       = 0;
        accepted  = 0;
        held      = 8'h00;
        op        = ADD;
        in0       = bp_a[0];
        in1       = bp_a[0];
        in_valid  = 1'b1;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            took = in_ready;
            if (took) accepted++;
            if (cyc == 2) held = out;
            if (cyc > 2) checkOutput("bp_hold", {24'd0, out}, {24'd0, held});
            @(posedge clk);
            #1;
            if (took) begin
                idx++;
                if (idx < 4) begin
                    in0 = bp_a[idx];
                    in1 = bp_a[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        checkOutput("bp_accepts", accepted, 32'd2);
        checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("bp_out_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("bp_out", {24'd0, out}, 32'h02);
        out_ready = 1'b1;
        guard = 0;
        while (idx < 4 && guard < 50) begin
            in0 = bp_a[idx];
            in1 = bp_a[idx];
            in_valid = 1'b1;
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
            if (took) idx++;
            guard++;
        end
        waitDrain();
        checkOutput("bp_pop_count", pops - pops_before, 32'd4);

        // Reset with two transactions in flight and the consumer stalled.
        out_ready = 1'b0;
        applyStimulus(ACC_LD, 8'h00, 8'h33, 8'h33, 1'b0, 1'b0, 1'b0);
        applyStimulus(ADD,    8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("pre_rst_acc", {24'd0, acc}, 32'h33);
        checkOutput("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("mid_rst_acc", {24'd0, acc}, 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("post_rst_quiet", {31'd0, out_valid}, 32'd0);
        end
        @(posedge clk);
        #1;

        applyStimulus(ACC_ADD, 8'h99, 8'h10, 8'h10, 1'b0, 1'b0, 1'b0);
        applyStimulus(ADD,     8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1);
        waitDrain();
        checkOutput("post_rst_acc", {24'd0, acc}, 32'h10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
